// File: rtl/io_arb_pkg.sv
// Shared types and constants for the I/O bus arbiter.
package io_arb_pkg;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Bits needed to index n items; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester, response and I/O-block signals of the arbiter; slave = arbiter view.
interface io_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 24
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*32-1:0]     req_wdata;
    logic [N_REQ*2-1:0]      req_width;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [31:0]             rsp_rdata;
    logic [ADDR_W-1:0]       io_addr;
    logic [31:0]             io_data_in;
    logic                    io_read;
    logic                    io_write;
    logic [1:0]              io_width;
    logic [31:0]             io_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_width, req_lock, io_data_out,
        output req_ready, rsp_valid, rsp_rdata, io_addr, io_data_in, io_read, io_write, io_width
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_width, req_lock, io_data_out,
        input  req_ready, rsp_valid, rsp_rdata, io_addr, io_data_in, io_read, io_write, io_width
    );
endinterface

// File: rtl/io_arb_prio_enc.sv
// Lowest-index-first one-hot priority encoder with any-valid flag.
module io_arb_prio_enc #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);
    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;
endmodule

// File: rtl/io_bus_arbiter.sv
// Fixed-priority arbiter with bus lock in front of the I/O register block.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic           clk_mem,
    input  logic           rst,
    io_bus_arbiter_if.slave bus
);
    localparam int unsigned TAG_W = clog2(N_REQ);
    localparam int unsigned CNT_W = clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [TAG_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  idle_q, idle_d, idle_inc;

    logic [N_REQ-1:0]  owner_mask, cand, gnt;
    logic              any_gnt;
    logic [TAG_W-1:0]  gnt_idx;

    logic              io_read_q, io_read_d, io_write_q, io_write_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [31:0]       io_data_in_q, io_data_in_d;
    logic [1:0]        io_width_q, io_width_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    // While locked, only the owner competes.
    assign owner_mask = N_REQ'(1) << owner_q;
    assign cand       = (state_q == ARB_LOCKED) ? (bus.req_valid & owner_mask) : bus.req_valid;

    io_arb_prio_enc #(.N(N_REQ)) u_prio_enc (
        .req (cand),
        .gnt (gnt),
        .any (any_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) gnt_idx = TAG_W'(i);
        end
    end

    assign bus.req_ready = gnt;

    // Lock FSM and saturating idle counter.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        idle_d   = idle_q;
        idle_inc = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_W'(1);
        case (state_q)
            ARB_OPEN: begin
                if (any_gnt && bus.req_lock[gnt_idx]) begin
                    state_d = ARB_LOCKED;
                    owner_d = gnt_idx;
                    idle_d  = '0;
                end
            end
            ARB_LOCKED: begin
                if (any_gnt) begin
                    idle_d = '0;
                    if (!bus.req_lock[gnt_idx]) state_d = ARB_OPEN;
                end else if (idle_inc == CNT_MAX) begin
                    state_d = ARB_OPEN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    // Issue and response stages.
    always_comb begin
        io_read_d    = any_gnt & ~bus.req_write[gnt_idx];
        io_write_d   = any_gnt &  bus.req_write[gnt_idx];
        io_addr_d    = io_addr_q;
        io_data_in_d = io_data_in_q;
        io_width_d   = io_width_q;
        tag_d        = tag_q;
        if (any_gnt) begin
            io_addr_d    = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            io_data_in_d = bus.req_wdata[gnt_idx*32 +: 32];
            io_width_d   = bus.req_width[gnt_idx*2 +: 2];
            tag_d        = gnt_idx;
        end
        rsp_valid_d = (io_read_q || io_write_q) ? (N_REQ'(1) << tag_q) : '0;
        rsp_rdata_d = io_read_q ? bus.io_data_out : 32'd0;
    end

    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_OPEN;
            owner_q      <= '0;
            idle_q       <= '0;
            io_read_q    <= 1'b0;
            io_write_q   <= 1'b0;
            io_addr_q    <= '0;
            io_data_in_q <= '0;
            io_width_q   <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            idle_q       <= idle_d;
            io_read_q    <= io_read_d;
            io_write_q   <= io_write_d;
            io_addr_q    <= io_addr_d;
            io_data_in_q <= io_data_in_d;
            io_width_q   <= io_width_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus.io_read    = io_read_q;
    assign bus.io_write   = io_write_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_data_in = io_data_in_q;
    assign bus.io_width   = io_width_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single port of the memory-mapped I/O register block (timers TM0–TM3 at 0x100–0x10C and later I/O registers) between several bus masters: DMA channels and the CPU. Fixed priority, optional bus lock for DMA bursts, and a registered one-transaction-per-cycle pipeline. The I/O block keeps its combinational read and posedge write. Sits between the masters' memory interface and the I/O register block, in the clk_mem domain.

## Interface
- N_REQ, 3: number of requesters; index 0 is highest priority, index N_REQ-1 is the CPU.
- ADDR_W, 24: I/O address width.
- LOCK_TIMEOUT, 16: idle cycles after which a held lock is force-released; minimum 1.

- clk_mem  in  1  memory clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a transaction pending.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  byte address, slice i.
- req_wdata  in  N_REQ*32  write data, low-aligned, slice i.
- req_width  in  N_REQ*2  0 = byte, 1 = half, 2 or 3 = word.
- req_lock  in  N_REQ  keep ownership after this transaction.
- req_ready  out  N_REQ  combinational one-hot; the transaction is accepted in the cycle where valid and ready are both high.
- rsp_valid  out  N_REQ  one-hot completion pulse.
- rsp_rdata  out  32  read data; 0 for writes.
- io_addr  out  ADDR_W  registered address to the I/O block.
- io_data_in  out  32  registered write data.
- io_read / io_write  out  1  registered one-cycle strobes, mutually exclusive.
- io_width  out  2  registered width.
- io_data_out  in  32  combinational read data from the I/O block.

## Operation
- State machine: OPEN and LOCKED, plus owner index and idle counter.
- **OPEN:** ready goes to the lowest-index requester with valid=1.
  - If the accepted transaction has lock=1, go to LOCKED with owner = that index and idle counter = 0.
- **LOCKED:** only the owner can get ready, whatever the other requests.
  - An accepted owner transaction with lock=0 returns to OPEN; the next grant is arbitrated in the following cycle.
  - Each cycle the owner has valid=0, the idle counter increments. When the counter reaches LOCK_TIMEOUT, return to OPEN.
  - An accepted owner transaction clears the idle counter.
- **Issue stage:** an accepted transaction is registered onto io_* with io_read or io_write high for exactly one cycle. If nothing is accepted, the strobes are 0 and addr/data/width hold their last values.
- **Response stage:** one cycle after issue, rsp_valid[i] pulses for the originating index.
  - Reads: rsp_rdata = io_data_out sampled in the issue cycle.
  - Writes: rsp_rdata = 0.
  - Responses return in acceptance order; the pipeline carries a 2-bit-or-wider index tag.
- Address, width and data pass through unchanged. Shift and mask handling belongs to the I/O block.
- Width 3 is forwarded as 3; the I/O block treats it as word.

## Timing
- Accept at cycle T (combinational ready) → io strobe at T+1 → rsp_valid at T+2.
  - Read latency: 2 cycles.
  - Throughput: 1 transaction per cycle, back-to-back, including alternating requesters in OPEN.
- Values after reset:
  - req_ready follows the OPEN arbitration rule immediately.
  - rsp_valid = 0 and rsp_rdata = 0.
  - io_read = io_write = 0; io_addr, io_data_in and io_width = 0.
  - State OPEN, owner 0, idle counter 0.
- Reset mid-operation: in-flight issue and response stages are discarded; no rsp_valid is produced for them.
- Simultaneous lock release and a new request from a higher-priority index: the release takes effect after the edge, so the new grant appears at T+1, never in the same cycle.
- Timeout and owner valid in the same cycle: the owner is served and the counter is cleared; no release happens.
- The idle counter saturates and must not wrap.

## Structure
- Package io_arb_pkg holds:
  - the state enum (ARB_OPEN, ARB_LOCKED);
  - width constants W_BYTE = 2'd0, W_HALF = 2'd1, W_WORD = 2'd2;
  - the response-tag width function clog2(N_REQ).
- One sub-module, io_arb_prio_enc: parameterised lowest-index-first one-hot priority encoder with an any-valid flag.

## Test plan
- Single read from CPU (idx 2) at 0x100, with io_data_out = 0x0080_1234 → io_read pulses at T+1 with addr 0x100; rsp_valid[2] and rsp_rdata = 0x0080_1234 at T+2.
- Requesters 0 and 2 valid in the same cycle with writes to 0x104 and 0x108 → ready[0] first; ready[2] in the next cycle; io_write addresses in order 0x104, 0x108; rsp_valid pulses [0] then [2].
- Requester 1 issues 4 locked writes (lock = 1,1,1,0) while CPU is held valid → CPU gets no ready until the cycle after the lock=0 accept; CPU then reads with 2-cycle latency.
- Requester 0 locks, then drops valid with LOCK_TIMEOUT = 16 → CPU ready after exactly 16 idle cycles, not 15.
- rst asserted for 1 cycle at T+1 after a read accept → no rsp_valid; all io_* outputs and rsp_rdata read 0 asynchronously during rst.
- Byte write, width 0, addr 0x10E, wdata 0x83 → io_width = 0, io_data_in = 0x83, io_addr = 0x10E unchanged; rsp_rdata = 0.
